// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe win detector:
// FSM states, scan result kinds and the eight line masks.
package ttt_pkg;

   localparam int NUM_CELLS = 9;
   localparam int NUM_LINES = 8;
   localparam logic [NUM_CELLS-1:0] FULL_BOARD = 9'h1FF;

   // Packed index l is line l: rows 0-2, columns 3-5, diagonals 6-7.
   localparam logic [NUM_LINES-1:0][NUM_CELLS-1:0] LINE_MASK = {
      9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
   };

   typedef enum logic [1:0] {PLAY, SCAN, PULSE, OVER} state_e;
   typedef enum logic [1:0] {RES_X, RES_O, RES_DRAW} res_e;

endpackage

// File: rtl/ttt_line_check.sv
// Combinational test of one board line against the X and O occupancy maps.
module ttt_line_check
   import ttt_pkg::*;
(
   input  logic [NUM_CELLS-1:0] mask,
   input  logic [NUM_CELLS-1:0] x,
   input  logic [NUM_CELLS-1:0] o,
   output logic                 hit_x,
   output logic                 hit_o
);

   assign hit_x = (x & mask) == mask;
   assign hit_o = (o & mask) == mask;

endmodule

// File: rtl/ttt_win_detect.sv
// Scans a snapshot of the board one line per cycle after each move and
// emits win/draw pulses, then locks the board until new_game.
module ttt_win_detect
   import ttt_pkg::*;
#(
   parameter int WIN_PULSE_LEN = 1
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 move_valid,
   input  logic                 new_game,
   input  logic [NUM_CELLS-1:0] board_x,
   input  logic [NUM_CELLS-1:0] board_o,
   output logic                 busy,
   output logic                 game_over,
   output logic                 win_x,
   output logic                 win_o,
   output logic                 draw,
   output logic [2:0]           win_line
);

   state_e               state, nxt;
   res_e                 res;
   logic [2:0]           idx;
   logic [1:0]           pcnt;
   logic [NUM_CELLS-1:0] snap_x, snap_o;
   logic [NUM_LINES-1:0] hx, ho;
   logic                 sel_x, sel_o, full, pulse_last;

   for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
      ttt_line_check u_chk (
         .mask  (LINE_MASK[l]),
         .x     (snap_x),
         .o     (snap_o),
         .hit_x (hx[l]),
         .hit_o (ho[l])
      );
   end

   assign sel_x      = hx[idx];
   assign sel_o      = ho[idx];
   assign full       = (snap_x | snap_o) == FULL_BOARD;
   assign pulse_last = pcnt == 2'(WIN_PULSE_LEN - 1);

   always_comb begin
      nxt = state;
      case (state)
         PLAY:  if (move_valid) nxt = SCAN;
         SCAN: begin
            if (sel_x || sel_o)  nxt = PULSE;
            else if (idx == 3'd7) nxt = full ? PULSE : PLAY;
         end
         PULSE: if (pulse_last) nxt = OVER;
         OVER:  nxt = OVER;
         default: nxt = PLAY;
      endcase
      if (new_game) nxt = PLAY;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= PLAY;
         res      <= RES_X;
         idx      <= '0;
         pcnt     <= '0;
         snap_x   <= '0;
         snap_o   <= '0;
         win_line <= '0;
      end else begin
         state <= nxt;
         if (new_game) begin
            idx      <= '0;
            pcnt     <= '0;
            win_line <= '0;
         end else begin
            case (state)
               PLAY: if (move_valid) begin
                  snap_x <= board_x;
                  snap_o <= board_o;
                  idx    <= '0;
               end
               SCAN: begin
                  idx  <= idx + 3'd1;
                  pcnt <= '0;
                  // X takes priority when an illegal board completes a line for both
                  if (sel_x || sel_o) begin
                     win_line <= idx;
                     res      <= sel_x ? RES_X : RES_O;
                  end else if (idx == 3'd7) begin
                     win_line <= '0;
                     res      <= RES_DRAW;
                  end
               end
               PULSE: pcnt <= pcnt + 2'd1;
               default: ;
            endcase
         end
      end
   end

   assign busy      = state == SCAN;
   assign game_over = (state == PULSE) || (state == OVER);
   assign win_x     = (state == PULSE) && (res == RES_X);
   assign win_o     = (state == PULSE) && (res == RES_O);
   assign draw      = (state == PULSE) && (res == RES_DRAW);

endmodule

// File: tb/tb_ttt_win_detect.sv
// Randomized and directed bench for ttt_win_detect with pulse lengths 1 and 2.
module tb_ttt_win_detect;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       move_valid = 1'b0;
   logic       new_game = 1'b0;
   logic [8:0] board_x = '0;
   logic [8:0] board_o = '0;

   logic       busy1, go1, wx1, wo1, dr1;
   logic [2:0] wl1;
   logic       busy2, go2, wx2, wo2, dr2;
   logic [2:0] wl2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ttt_win_detect #(.WIN_PULSE_LEN(1)) dut1 (
      .clk(clk), .reset(reset), .move_valid(move_valid), .new_game(new_game),
      .board_x(board_x), .board_o(board_o), .busy(busy1), .game_over(go1),
      .win_x(wx1), .win_o(wo1), .draw(dr1), .win_line(wl1));

   ttt_win_detect #(.WIN_PULSE_LEN(2)) dut2 (
      .clk(clk), .reset(reset), .move_valid(move_valid), .new_game(new_game),
      .board_x(board_x), .board_o(board_o), .busy(busy2), .game_over(go2),
      .win_x(wx2), .win_o(wo2), .draw(dr2), .win_line(wl2));

   wire [7:0] v1 = {busy1, go1, wx1, wo1, dr1, wl1};
   wire [7:0] v2 = {busy2, go2, wx2, wo2, dr2, wl2};

   // downstream saturating 3-bit win counters fed by the X pulses
   logic       clr_cnt = 1'b0;
   logic [2:0] cnt1, cnt2;
   logic       px1, px2;
   int         cyc1, cyc2;
   always @(posedge clk) begin
      if (clr_cnt) begin
         cnt1 <= '0; cnt2 <= '0; px1 <= 1'b0; px2 <= 1'b0; cyc1 <= 0; cyc2 <= 0;
      end else begin
         if (wx1 && !px1 && cnt1 != 3'd7) cnt1 <= cnt1 + 3'd1;
         if (wx2 && !px2 && cnt2 != 3'd7) cnt2 <= cnt2 + 3'd1;
         px1 <= wx1; px2 <= wx2;
         cyc1 <= cyc1 + int'(wx1);
         cyc2 <= cyc2 + int'(wx2);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // kind: 0 none, 1 X, 2 O, 3 draw; lat = cycles spent scanning
   function automatic void ref_model(input logic [8:0] x, input logic [8:0] o,
                                     output int kind, output int line, output int lat);
      int c[3];
      kind = 0; line = 0; lat = 8;
      for (int k = 0; k < 8; k++) begin
         if (k < 3)       for (int i = 0; i < 3; i++) c[i] = k * 3 + i;
         else if (k < 6)  for (int i = 0; i < 3; i++) c[i] = i * 3 + (k - 3);
         else if (k == 6) for (int i = 0; i < 3; i++) c[i] = i * 4;
         else             for (int i = 0; i < 3; i++) c[i] = 2 + i * 2;
         if (x[c[0]] && x[c[1]] && x[c[2]]) begin kind = 1; line = k; lat = k + 1; return; end
         if (o[c[0]] && o[c[1]] && o[c[2]]) begin kind = 2; line = k; lat = k + 1; return; end
      end
      if ((x | o) == 9'h1FF) kind = 3;
   endfunction

   function automatic logic [7:0] exp_vec(input int len, input int kind, input int line,
                                          input int lat, input int j);
      logic act, pul;
      act = (kind != 0) && (j >= lat);
      pul = act && (j < lat + len);
      return {j < lat, act, pul && kind == 1, pul && kind == 2, pul && kind == 3,
              (act && kind < 3) ? 3'(line) : 3'd0};
   endfunction

   task automatic start_game();
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      chk("newgame_v1", {24'd0, v1}, 32'd0);
      chk("newgame_v2", {24'd0, v2}, 32'd0);
   endtask

   task automatic run_move(input logic [8:0] x, input logic [8:0] o, input bit spur);
      int kind, line, lat;
      ref_model(x, o, kind, line, lat);
      @(negedge clk);
      board_x = x; board_o = o; move_valid = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
      board_x = 9'($urandom); board_o = 9'($urandom);
      for (int j = 0; j < 14; j++) begin
         chk($sformatf("x%03h_o%03h_j%0d_len1", x, o, j), {24'd0, v1}, {24'd0, exp_vec(1, kind, line, lat, j)});
         chk($sformatf("x%03h_o%03h_j%0d_len2", x, o, j), {24'd0, v2}, {24'd0, exp_vec(2, kind, line, lat, j)});
         move_valid = spur && (j == 1 || j == lat + 1) && (j < lat || kind != 0);
         if (move_valid) begin board_x = 9'h1C0; board_o = 9'h000; end
         @(negedge clk);
      end
      move_valid = 1'b0;
   endtask

   initial begin
      logic [8:0] rx, ro;
      #12;
      chk("reset_v1", {24'd0, v1}, 32'd0);
      chk("reset_v2", {24'd0, v2}, 32'd0);
      reset = 1'b1;

      run_move(9'h007, 9'h018, 1'b0); start_game();
      run_move(9'h00A, 9'h111, 1'b1); start_game();
      run_move(9'h0CB, 9'h134, 1'b0); start_game();
      run_move(9'h003, 9'h010, 1'b1); start_game();
      run_move(9'h007, 9'h007, 1'b0); start_game();

      // abort mid-scan with new_game while idx=3
      @(negedge clk);
      board_x = 9'h124; board_o = 9'h003; move_valid = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
      repeat (3) @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      for (int j = 0; j < 10; j++) begin
         chk($sformatf("abort_j%0d", j), {24'd0, v1, v2}, 32'd0);
         @(negedge clk);
      end

      // new_game wins over a same-cycle move
      board_x = 9'h007; board_o = 9'h000; move_valid = 1'b1; new_game = 1'b1;
      @(negedge clk);
      move_valid = 1'b0; new_game = 1'b0;
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("dropmove_j%0d", j), {24'd0, v1, v2}, 32'd0);
         @(negedge clk);
      end

      // asynchronous reset mid-scan
      board_x = 9'h054; board_o = 9'h003; move_valid = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
      @(negedge clk);
      chk("prereset_busy", {30'd0, busy1, busy2}, 32'd3);
      reset = 1'b0;
      #1;
      chk("async_reset", {24'd0, v1, v2}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int j = 0; j < 10; j++) begin
         chk($sformatf("postreset_j%0d", j), {24'd0, v1, v2}, 32'd0);
         @(negedge clk);
      end

      // eight X wins into the downstream counters
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      for (int g = 0; g < 8; g++) begin
         run_move(9'h007, 9'h018, 1'b0);
         start_game();
      end
      chk("counter_len1", {29'd0, cnt1}, 32'd7);
      chk("counter_len2", {29'd0, cnt2}, 32'd7);
      chk("pulsecyc_len1", cyc1, 32'd8);
      chk("pulsecyc_len2", cyc2, 32'd16);

      // random legal boards
      for (int g = 0; g < 40; g++) begin
         rx = '0; ro = '0;
         for (int c = 0; c < 9; c++) begin
            case ($urandom_range(0, 2))
               1: rx[c] = 1'b1;
               2: ro[c] = 1'b1;
               default: ;
            endcase
         end
         run_move(rx, ro, 1'($urandom_range(0, 1)));
         start_game();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
